// File: rtl/packetizer_sequencer.sv
// Run controller for the GReX packetizer: soft reset, PPS-aligned start, packet
// counting, clean stop on a packet boundary, plus a tx framing checker.
module packetizer_sequencer #(
  parameter int PKT_WORDS     = 1025,
  parameter int RST_CYCLES    = 16,
  parameter int DRAIN_TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        arm,
  input  logic        disarm,
  input  logic        pps,
  input  logic [31:0] n_packets,
  output logic        dp_rst,
  output logic        dp_ce,
  output logic        dp_sync,
  input  logic        tx_valid,
  input  logic        tx_eod,
  output logic [2:0]  state_o,
  output logic [31:0] pkt_count,
  output logic        len_err,
  output logic        drain_timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SRST  = 3'd1;
  localparam logic [2:0] S_ARMED = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_DRAIN = 3'd4;
  localparam logic [2:0] S_STOP  = 3'd5;

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam int DCW = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
  localparam int WCW = $clog2(PKT_WORDS + 1) + 1;

  logic [2:0]     state;
  logic [2:0]     state_nxt;
  logic           pps_d;
  logic           pps_rise_q;
  logic [RCW-1:0] rst_cnt;
  logic [DCW-1:0] drain_cnt;
  logic [WCW-1:0] word_cnt;
  logic [WCW:0]   pkt_len;
  logic           inflight;
  logic [31:0]    pkt_inc;
  logic           active;
  logic           rst_last;
  logic           drain_last;
  logic           timeout_hit;

  assign state_o    = state;
  assign active     = (state == S_RUN) || (state == S_DRAIN);
  assign pkt_inc    = (pkt_count == 32'hFFFF_FFFF) ? pkt_count : pkt_count + 32'd1;
  assign rst_last   = (rst_cnt == RCW'(RST_CYCLES - 1));
  assign drain_last = (drain_cnt == DCW'(DRAIN_TIMEOUT - 1));
  assign pkt_len    = {1'b0, word_cnt} + (WCW + 1)'(tx_valid);
  // An eod always wins over the timeout in the same cycle.
  assign timeout_hit = (state == S_DRAIN) && inflight && !tx_eod && drain_last;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (arm) state_nxt = S_SRST;
      S_SRST:  if (rst_last) state_nxt = S_ARMED;
      S_ARMED: if (pps_rise_q) state_nxt = S_RUN;
      S_RUN: begin
        if (tx_eod && (n_packets != 32'd0) && (pkt_inc == n_packets))
          state_nxt = S_STOP;
        else if (disarm)
          state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (!inflight || tx_eod || drain_last)
          state_nxt = S_STOP;
      end
      S_STOP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_o.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      pps_d         <= 1'b0;
      pps_rise_q    <= 1'b0;
      rst_cnt       <= '0;
      drain_cnt     <= '0;
      word_cnt      <= '0;
      inflight      <= 1'b0;
      pkt_count     <= 32'd0;
      len_err       <= 1'b0;
      drain_timeout <= 1'b0;
      dp_rst        <= 1'b1;
      dp_ce         <= 1'b0;
      dp_sync       <= 1'b0;
    end else begin
      state      <= state_nxt;
      pps_d      <= pps;
      // Edges seen outside ARMED are dropped rather than queued.
      pps_rise_q <= pps & ~pps_d & (state == S_ARMED);
      dp_rst     <= (state_nxt == S_IDLE) || (state_nxt == S_SRST);
      dp_ce      <= (state_nxt == S_RUN) || (state_nxt == S_DRAIN);
      dp_sync    <= (state == S_ARMED) && (state_nxt == S_RUN);
      rst_cnt    <= (state == S_SRST) ? rst_cnt + RCW'(1) : '0;
      drain_cnt  <= (state == S_DRAIN) ? drain_cnt + DCW'(1) : '0;

      if (state == S_IDLE && arm) begin
        pkt_count     <= 32'd0;
        len_err       <= 1'b0;
        drain_timeout <= 1'b0;
      end else if (active && tx_eod) begin
        pkt_count <= pkt_inc;
      end

      if (timeout_hit)
        drain_timeout <= 1'b1;

      if (active) begin
        if (tx_eod) begin
          if (!tx_valid || (pkt_len != (WCW + 1)'(PKT_WORDS)))
            len_err <= 1'b1;
          word_cnt <= '0;
          inflight <= 1'b0;
        end else if (tx_valid) begin
          if (word_cnt != {WCW{1'b1}})
            word_cnt <= word_cnt + WCW'(1);
          inflight <= 1'b1;
        end else if (inflight) begin
          len_err <= 1'b1;
        end
      end else begin
        word_cnt <= '0;
        inflight <= 1'b0;
      end
    end
  end

endmodule
